// File: rtl/merlin_icache_dm.sv
// merlin_icache_dm: direct-mapped, read-only instruction cache.
// The front side accepts one PFU fetch at a time. Hits answer on the next
// cycle. A miss refills the whole line over the memory bus (one line request,
// then data beats in ascending order) and then returns the requested word.
// Optional build macro: MERLIN_ICACHE_STATS_EN adds hit/miss counters.
module merlin_icache_dm #(
   parameter int C_SETS_X       = 6,
   parameter int C_LINE_WORDS_X = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        clk_en_i,
   input  logic        inv_i,
   output logic        ireqready_o,
   input  logic        ireqvalid_i,
   input  logic [1:0]  ireqhpl_i,
   input  logic [31:0] ireqaddr_i,
   input  logic        irspready_i,
   output logic        irspvalid_o,
   output logic        irsprerr_o,
   output logic [31:0] irspdata_o,
   input  logic        mreqready_i,
   output logic        mreqvalid_o,
   output logic [1:0]  mreqhpl_o,
   output logic [31:0] mreqaddr_o,
   input  logic        mrspvalid_i,
   input  logic        mrsprerr_i,
   input  logic [31:0] mrspdata_i
`ifdef MERLIN_ICACHE_STATS_EN
   ,
   output logic [31:0] stat_hits_o,
   output logic [31:0] stat_misses_o
`endif
);

   localparam int NLINES  = 1 << C_SETS_X;
   localparam int NWORDS  = 1 << C_LINE_WORDS_X;
   localparam int IDX_LSB = 2 + C_LINE_WORDS_X;
   localparam int TAG_LSB = IDX_LSB + C_SETS_X;
   localparam int TAG_W   = 32 - TAG_LSB;

   typedef enum logic [1:0] {
      LOOKUP      = 2'd0,
      REFILL_REQ  = 2'd1,
      REFILL_DATA = 2'd2,
      RESPOND     = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [31:0]               addr_q;
   logic [1:0]                hpl_q;
   logic                      lookup_q, hit_q;
   logic [C_LINE_WORDS_X-1:0] beat_q;
   logic                      err_q, inv_seen_q;
   logic                      rsp_valid_q, rsp_err_q;
   logic [31:0]               rsp_data_q;

   logic [NLINES-1:0]         valid_q;
   logic [TAG_W-1:0]          tag_q  [NLINES];
   logic [31:0]               data_q [NLINES][NWORDS];

   logic [C_LINE_WORDS_X-1:0] in_off, req_off;
   logic [C_SETS_X-1:0]       in_idx, req_idx;
   logic [TAG_W-1:0]          in_tag, req_tag;
   logic                      hit_in, miss, accept, rsp_hs, beat_fire, last_beat;
   logic                      unused_addr_bits;

   assign in_off  = ireqaddr_i[2 +: C_LINE_WORDS_X];
   assign in_idx  = ireqaddr_i[IDX_LSB +: C_SETS_X];
   assign in_tag  = ireqaddr_i[31:TAG_LSB];
   assign req_off = addr_q[2 +: C_LINE_WORDS_X];
   assign req_idx = addr_q[IDX_LSB +: C_SETS_X];
   assign req_tag = addr_q[31:TAG_LSB];
   assign unused_addr_bits = ^{addr_q[1:0]};

   // The lookup is resolved at accept time so the hit result survives an invalidate.
   assign hit_in    = valid_q[in_idx] & (tag_q[in_idx] == in_tag);
   assign miss      = lookup_q & ~hit_q;
   assign accept    = ireqvalid_i & ireqready_o;
   assign rsp_hs    = rsp_valid_q & irspready_i;
   assign beat_fire = (state_q == REFILL_DATA) & mrspvalid_i & ~reset_i;
   assign last_beat = beat_fire & (beat_q == C_LINE_WORDS_X'(NWORDS - 1));

   assign irspvalid_o = rsp_valid_q;
   assign irsprerr_o  = rsp_err_q;
   assign irspdata_o  = rsp_data_q;
   assign mreqhpl_o   = hpl_q;
   assign mreqaddr_o  = {addr_q[31:IDX_LSB], {IDX_LSB{1'b0}}};

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= LOOKUP;
      end else if (clk_en_i) begin
         state_q <= state_d;
      end
   end

   // Next-state logic, fetch-ready and line-request strobes.
   always_comb begin
      logic ready_s;
      state_d     = state_q;
      ready_s     = 1'b0;
      mreqvalid_o = 1'b0;
      case (state_q)
         LOOKUP: begin
            ready_s = ~miss & (~rsp_valid_q | irspready_i);
            if (miss) state_d = REFILL_REQ;
            else      state_d = LOOKUP;
         end
         REFILL_REQ: begin
            mreqvalid_o = 1'b1;
            if (mreqready_i) state_d = REFILL_DATA;
            else             state_d = REFILL_REQ;
         end
         REFILL_DATA: begin
            if (last_beat) state_d = RESPOND;
            else           state_d = REFILL_DATA;
         end
         RESPOND: begin
            ready_s = irspready_i;
            if (irspready_i) state_d = LOOKUP;
            else             state_d = RESPOND;
         end
         default: state_d = LOOKUP;
      endcase
      ireqready_o = ready_s & ~inv_i & ~reset_i & clk_en_i;
   end

   // Request capture, response registers and refill bookkeeping.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         lookup_q    <= 1'b0;
         hit_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         beat_q      <= '0;
         err_q       <= 1'b0;
         inv_seen_q  <= 1'b0;
      end else if (clk_en_i) begin
         if (accept) begin
            addr_q      <= ireqaddr_i;
            hpl_q       <= ireqhpl_i;
            lookup_q    <= 1'b1;
            hit_q       <= hit_in;
            rsp_valid_q <= hit_in;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= data_q[in_idx][in_off];
         end else begin
            lookup_q <= 1'b0;
            if (rsp_hs) rsp_valid_q <= 1'b0;
         end
         if ((state_q == LOOKUP) && miss) begin
            beat_q     <= '0;
            err_q      <= 1'b0;
            inv_seen_q <= 1'b0;
         end
         if (((state_q == REFILL_REQ) || (state_q == REFILL_DATA)) && inv_i) begin
            inv_seen_q <= 1'b1;
         end
         if (beat_fire) begin
            beat_q <= beat_q + C_LINE_WORDS_X'(1);
            err_q  <= err_q | mrsprerr_i;
            if (beat_q == req_off) rsp_data_q <= mrspdata_i;
         end
         if (last_beat) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q | mrsprerr_i;
         end
      end
   end

   // Valid bits: cleared by reset or invalidate, set only by a clean refill.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= '0;
      end else if (clk_en_i) begin
         if (inv_i) begin
            valid_q <= '0;
         end else if (last_beat) begin
            valid_q[req_idx] <= ~(err_q | mrsprerr_i) & ~inv_seen_q;
         end
      end
   end

   // Tag and data storage, written by refill beats; never reset.
   always_ff @(posedge clk_i) begin
      if (clk_en_i && beat_fire) begin
         data_q[req_idx][beat_q] <= mrspdata_i;
         if (last_beat) tag_q[req_idx] <= req_tag;
      end
   end

`ifdef MERLIN_ICACHE_STATS_EN
   logic [31:0] hits_q, misses_q;
   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;

   // Hit and miss event counters, cleared by reset or invalidate.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hits_q   <= 32'd0;
         misses_q <= 32'd0;
      end else if (clk_en_i) begin
         if (inv_i) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
         end else begin
            if (accept && hit_in)               hits_q   <= hits_q + 32'd1;
            if ((state_q == LOOKUP) && miss)    misses_q <= misses_q + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_merlin_icache_dm.sv
// Self-checking bench for merlin_icache_dm: directed vector table, hand-written
// corner sequences and randomized fetches against a line-map reference model.
module tb_merlin_icache_dm;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, clk_en, inv;
   logic        ireqready, ireqvalid;
   logic [1:0]  ireqhpl;
   logic [31:0] ireqaddr;
   logic        irspready, irspvalid, irsprerr;
   logic [31:0] irspdata;
   logic        mreqready, mreqvalid;
   logic [1:0]  mreqhpl;
   logic [31:0] mreqaddr;
   logic        mrspvalid, mrsprerr;
   logic [31:0] mrspdata;
`ifdef MERLIN_ICACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses;
`endif

   merlin_icache_dm dut (
      .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .inv_i(inv),
      .ireqready_o(ireqready), .ireqvalid_i(ireqvalid), .ireqhpl_i(ireqhpl),
      .ireqaddr_i(ireqaddr), .irspready_i(irspready), .irspvalid_o(irspvalid),
      .irsprerr_o(irsprerr), .irspdata_o(irspdata), .mreqready_i(mreqready),
      .mreqvalid_o(mreqvalid), .mreqhpl_o(mreqhpl), .mreqaddr_o(mreqaddr),
      .mrspvalid_i(mrspvalid), .mrsprerr_i(mrsprerr), .mrspdata_i(mrspdata)
`ifdef MERLIN_ICACHE_STATS_EN
      , .stat_hits_o(stat_hits), .stat_misses_o(stat_misses)
`endif
   );

   typedef struct {
      logic [31:0] addr;
      int          errb;
      logic [31:0] exp_d;
      logic        exp_e;
      logic        exp_m;
   } vec_t;

   int total = 0;
   int bad   = 0;
   int refills = 0;
   int beats   = 0;
   int err_beat_cfg = -1;
   logic [31:0] last_line;
   logic [1:0]  last_hpl;

   // Memory contents: line 0x1000 holds 0xA0..0xA3, elsewhere an address hash.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if ((a >> 4) == 32'h100) return 32'hA0 + ((a >> 2) & 32'h3);
      else                     return (a & 32'hFFFF_FFFC) ^ 32'h5EED_C0DC;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", nm);
   endtask

   // Memory model: accepts a line request after a random delay, then sends
   // four ascending beats with random gaps; beat err_beat_cfg carries an error.
   initial begin
      mreqready = 1'b0; mrspvalid = 1'b0; mrsprerr = 1'b0; mrspdata = 32'h0;
      last_line = 32'h0; last_hpl = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (mreqvalid && !reset) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            mreqready = 1'b1; last_line = mreqaddr; last_hpl = mreqhpl;
            @(posedge clk); #1;
            mreqready = 1'b0; refills++;
            for (int k = 0; k < 4; k++) begin
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
               mrspvalid = 1'b1;
               mrspdata  = mem_word(last_line + 32'(k * 4));
               mrsprerr  = (k == err_beat_cfg);
               @(posedge clk); #1;
               mrspvalid = 1'b0; mrsprerr = 1'b0; beats++;
            end
         end
      end
   end

   // Drive a request and wait (bounded) for it to be accepted; returns after the edge.
   task automatic req_accept(input logic [31:0] a, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      ireqvalid = 1'b1; ireqaddr = a;
      for (int c = 0; c < 300; c++) begin
         #1;
         if (ireqready) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (ok) begin @(posedge clk); #1; end
      ireqvalid = 1'b0;
   endtask

   task automatic do_fetch(input logic [31:0] a, input int errb, input logic [31:0] exp_d,
                           input logic exp_e, input logic exp_m, input string nm);
      int r0, b0, lat;
      bit ok;
      logic [1:0] h;
      r0 = refills; b0 = beats; err_beat_cfg = errb;
      h = 2'($urandom_range(0, 3)); ireqhpl = h;
      req_accept(a, ok);
      if (!ok) begin fail_now({nm, "_accept"}); return; end
      ok = 1'b0; lat = 0;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (irspvalid) begin ok = 1'b1; lat = c; break; end
      end
      if (!ok) begin fail_now({nm, "_rsp"}); return; end
      check({nm, "_data"}, irspdata, exp_d);
      check({nm, "_err"}, 32'(irsprerr), 32'(exp_e));
      check({nm, "_refills"}, 32'(refills - r0), exp_m ? 32'd1 : 32'd0);
      if (exp_m) begin
         check({nm, "_beats"}, 32'(beats - b0), 32'd4);
         check({nm, "_line"}, last_line, a & 32'hFFFF_FFF0);
         check({nm, "_hpl"}, 32'(last_hpl), 32'(h));
      end else begin
         check({nm, "_hitlat"}, 32'(lat), 32'd0);
      end
      @(posedge clk); #1;
      err_beat_cfg = -1;
   endtask

   // Three back-to-back hits on line 0x1000 with the request held continuously.
   task automatic stream_seq();
      int r0;
      r0 = refills;
      @(negedge clk);
      ireqvalid = 1'b1; ireqaddr = 32'h1000;
      #1 check("stream_rdy0", 32'(ireqready), 32'd1);
      @(posedge clk); #1 ireqaddr = 32'h1008;
      @(negedge clk);
      check("stream_v0", 32'(irspvalid), 32'd1);
      check("stream_d0", irspdata, 32'hA0);
      check("stream_rdy1", 32'(ireqready), 32'd1);
      @(posedge clk); #1 ireqaddr = 32'h100C;
      @(negedge clk);
      check("stream_v1", 32'(irspvalid), 32'd1);
      check("stream_d1", irspdata, 32'hA2);
      @(posedge clk); #1 ireqvalid = 1'b0;
      @(negedge clk);
      check("stream_v2", 32'(irspvalid), 32'd1);
      check("stream_d2", irspdata, 32'hA3);
      check("stream_nomreq", 32'(mreqvalid), 32'd0);
      @(posedge clk); #1;
      check("stream_refills", 32'(refills - r0), 32'd0);
      @(negedge clk);
      check("stream_idle", 32'(irspvalid), 32'd0);
   endtask

   vec_t vt[6];
   bit   mvalid[64];
   int   mtag[64];

   initial begin
      int b0;
      bit ok;
      reset = 1'b1; clk_en = 1'b1; inv = 1'b0; ireqvalid = 1'b0;
      ireqaddr = 32'h0; ireqhpl = 2'b00; irspready = 1'b1;

      vt[0] = '{32'h0000_1004, -1, 32'hA1, 1'b0, 1'b1};
      vt[1] = '{32'h0000_1400, -1, mem_word(32'h1400), 1'b0, 1'b1};
      vt[2] = '{32'h0000_1000, -1, 32'hA0, 1'b0, 1'b1};
      vt[3] = '{32'h0000_2000,  2, mem_word(32'h2000), 1'b1, 1'b1};
      vt[4] = '{32'h0000_2000, -1, mem_word(32'h2000), 1'b0, 1'b1};
      vt[5] = '{32'h0000_2004, -1, mem_word(32'h2004), 1'b0, 1'b0};

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ireqready", 32'(ireqready), 32'd0);
      check("rst_irspvalid", 32'(irspvalid), 32'd0);
      check("rst_mreqvalid", 32'(mreqvalid), 32'd0);
      check("rst_irsprerr", 32'(irsprerr), 32'd0);
      reset = 1'b0;
      #1 check("post_rst_ready", 32'(ireqready), 32'd1);

      for (int i = 0; i < 6; i++) begin
         do_fetch(vt[i].addr, vt[i].errb, vt[i].exp_d, vt[i].exp_e, vt[i].exp_m, $sformatf("vec%0d", i));
         if (i == 0) stream_seq();
      end

      // Invalidate of a valid line forces a refill.
      do_fetch(32'h1000, -1, 32'hA0, 1'b0, 1'b1, "inv_fill");
      do_fetch(32'h1004, -1, 32'hA1, 1'b0, 1'b0, "inv_prehit");
      @(negedge clk); inv = 1'b1;
      #1 check("inv_blocks_ready", 32'(ireqready), 32'd0);
      @(negedge clk); inv = 1'b0;
      do_fetch(32'h1000, -1, 32'hA0, 1'b0, 1'b1, "inv_after");

      // Invalidate during a refill: data returned, line stays invalid.
      b0 = beats;
      fork
         do_fetch(32'h3008, -1, mem_word(32'h3008), 1'b0, 1'b1, "inv_refill");
         begin
            for (int c = 0; c < 300 && beats == b0; c++) @(negedge clk);
            inv = 1'b1;
            @(negedge clk);
            inv = 1'b0;
         end
      join
      do_fetch(32'h3008, -1, mem_word(32'h3008), 1'b0, 1'b1, "inv_refill_again");

      // Back-pressure on a hit for three cycles.
      irspready = 1'b0;
      @(negedge clk);
      ireqvalid = 1'b1; ireqaddr = 32'h3000;
      #1 check("bp_rdy_accept", 32'(ireqready), 32'd1);
      @(posedge clk); #1 ireqaddr = 32'h3004;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(irspvalid), 32'd1);
         check("bp_data", irspdata, mem_word(32'h3000));
         check("bp_rdy_low", 32'(ireqready), 32'd0);
      end
      irspready = 1'b1;
      #1 check("bp_rdy_release", 32'(ireqready), 32'd1);
      @(posedge clk); #1 ireqvalid = 1'b0;
      @(negedge clk);
      check("bp_next_valid", 32'(irspvalid), 32'd1);
      check("bp_next_data", irspdata, mem_word(32'h3004));
      @(posedge clk); #1;

      // Reset in the middle of a refill; leftover beats must be ignored.
      b0 = beats;
      req_accept(32'h5000, ok);
      if (!ok) fail_now("rstmid_accept");
      for (int c = 0; c < 300 && beats == b0; c++) @(negedge clk);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("rstmid_rspvalid", 32'(irspvalid), 32'd0);
      check("rstmid_mreqvalid", 32'(mreqvalid), 32'd0);
      for (int c = 0; c < 300 && beats < b0 + 4; c++) @(negedge clk);
      repeat (2) @(negedge clk);
      check("rstmid_drop_rsp", 32'(irspvalid), 32'd0);
      check("rstmid_drop_mreq", 32'(mreqvalid), 32'd0);
      do_fetch(32'h5004, -1, mem_word(32'h5004), 1'b0, 1'b1, "rstmid_refetch");

      // Randomized fetches against a line-map model (index = a/16 mod 64, tag = a/1024).
      @(negedge clk); inv = 1'b1;
      @(negedge clk); inv = 1'b0;
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      for (int n = 0; n < 120; n++) begin
         logic [31:0] a;
         int idx, tg, errb;
         logic em, ee;
         a = 32'h2000 + 32'($urandom_range(0, 3)) * 32'd1024
                      + 32'($urandom_range(0, 7)) * 32'd16
                      + 32'($urandom_range(0, 3)) * 32'd4;
         errb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1;
         if ($urandom_range(0, 15) == 0) begin
            @(negedge clk); inv = 1'b1;
            @(negedge clk); inv = 1'b0;
            for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
         end
         idx = int'((a / 32'd16) % 32'd64);
         tg  = int'(a / 32'd1024);
         em  = !(mvalid[idx] && mtag[idx] == tg);
         ee  = em && (errb >= 0);
         if (em) begin
            mvalid[idx] = !ee;
            mtag[idx]   = tg;
         end
         do_fetch(a, errb, mem_word(a), ee, em, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/merlin_icache_dm.md
Name: merlin_icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pre-fetch unit's instruction-cache interface and the memory bus.
- Front side: PFU ireq/irsp handshake, one outstanding request, 32-bit aligned words.
- Back side: issues line refills as a single line request followed by in-order data beats.
- Hits return the following cycle. Misses refill the whole line, then return the requested word.

Parameters:
- C_SETS_X, 6, log2 number of lines (64 lines).
- C_LINE_WORDS_X, 2, log2 words per line (4 words = 16 bytes); legal range 1..4.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- clk_en_i  in  1  clock enable; all state holds when low
- inv_i  in  1  invalidate-all pulse (fence.i)
- ireqready_o  out  1  cache can accept a fetch
- ireqvalid_i  in  1  fetch request
- ireqhpl_i  in  2  privilege level; forwarded to mreqhpl_o on refill
- ireqaddr_i  in  32  fetch address; bits [1:0] ignored
- irspready_i  in  1  PFU accepts response
- irspvalid_o  out  1  response valid
- irsprerr_o  out  1  fetch error
- irspdata_o  out  32  instruction word
- mreqready_i  in  1  memory accepts line request
- mreqvalid_o  out  1  line request
- mreqhpl_o  out  2  privilege of refill
- mreqaddr_o  out  32  line-aligned address (low 2+C_LINE_WORDS_X bits zero)
- mrspvalid_i  in  1  refill beat valid; always accepted
- mrsprerr_i  in  1  beat error
- mrspdata_i  in  32  beat data, ascending word order

Behaviour:
- Address split: offset = addr[2 +: C_LINE_WORDS_X]; index = next C_SETS_X bits; tag = remaining upper bits.
- Storage: valid bit, tag and data words per line, flop-based. Reset and inv_i clear all valid bits in one cycle; tags and data are not reset.
- FSM states: LOOKUP, REFILL_REQ, REFILL_DATA, RESPOND. Reset state is LOOKUP.
- Reset values: ireqready_o=0 for the reset cycle; irspvalid_o=0, mreqvalid_o=0, irsprerr_o=0. Data outputs are don't-care.
- Accept (LOOKUP):
  - ireqready_o = state==LOOKUP & ~inv_i & (~rsp_pending | irspready_i).
  - Accepting a request registers addr and hpl and sets lookup_q.
- Hit (cycle after accept, lookup_q & valid & tag match):
  - irspvalid_o=1 with the data word and irsprerr_o=0.
  - Back-to-back hits sustain 1 word/cycle while irspready_i stays high.
- Miss:
  - Go to REFILL_REQ: mreqvalid_o=1, mreqaddr_o = line base, held stable until mreqready_i.
  - Then REFILL_DATA: count beats 0..2^C_LINE_WORDS_X-1, write each beat into data[index][beat], OR mrsprerr_i into err_q.
  - After the last beat: tag written; valid set only if err_q==0 and no inv_i occurred during the refill. Go to RESPOND.
- RESPOND:
  - irspvalid_o=1 with word[offset] from the line buffer; irsprerr_o = err_q.
  - Return to LOOKUP on irspready_i.
  - A new request may be accepted in the same cycle as that handshake.
- Back-pressure: when irspvalid_o & ~irspready_i, outputs hold stable, rsp_pending=1, and no new accept.
- inv_i during LOOKUP with a response pending: the response is still delivered (it was already read). Subsequent lookups miss.
- inv_i during refill: the refill completes and the word is returned, but the line stays invalid.
- Reset mid-refill: FSM returns to LOOKUP and the beat counter clears. Any remaining memory beats are ignored while state != REFILL_DATA.
- Beats arriving outside REFILL_DATA are dropped.

Optional Feature:
- Macro MERLIN_ICACHE_STATS_EN.
- Defined:
  - Adds outputs stat_hits_o[31:0] and stat_misses_o[31:0].
  - Counters increment on a hit response / on entry to REFILL_REQ.
  - Clear on reset_i or inv_i; wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x0000_1004 with memory returning 0xA0,0xA1,0xA2,0xA3.
  - Required: mreqaddr_o=0x0000_1000, exactly 4 beats accepted, irspdata_o=0xA1, irsprerr_o=0.
- Hit streaming:
  - Stimulus: then fetch 0x1000, 0x1008, 0x100C back-to-back.
  - Required: responses 0xA0, 0xA2, 0xA3 on consecutive cycles, no mreqvalid_o.
- Conflict eviction:
  - Stimulus: fetch 0x0000_1400 (same index for C_SETS_X=6, 16B lines), then 0x1000 again.
  - Required: both miss and two refills are issued.
- Refill error:
  - Stimulus: beat 2 carries mrsprerr_i=1 on fetch 0x2000.
  - Required: irsprerr_o=1; a repeat fetch of 0x2000 misses again.
- Invalidate:
  - Stimulus: inv_i pulse after the line at 0x1000 is valid, then fetch 0x1000; separately, inv_i asserted during a refill.
  - Required: the fetch after the pulse refills; the refill in progress returns data but the next fetch misses.
- Back-pressure:
  - Stimulus: irspready_i=0 for 3 cycles on a hit.
  - Required: irspvalid_o and irspdata_o stable; ireqready_o=0 until the response handshake cycle.
